// File: rtl/dm_access_if.sv
// Pipeline-side MEM-stage request, data-memory handshake and writeback signals
// for the data-memory access controller.
interface dm_access_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_read_data;
  logic        err;

  // The controller itself.
  modport slave (
    input  mem_read, mem_write, addr, wdata, dm_ack, dm_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata, stall, wb_valid, wb_read_data, err
  );

  // The pipeline and memory side driving the controller.
  modport master (
    output mem_read, mem_write, addr, wdata, dm_ack, dm_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata, stall, wb_valid, wb_read_data, err
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller: registers one request, stalls the
// pipeline until dm_ack or a bounded timeout, then pulses wb_valid for one cycle.
module dm_access_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  dm_access_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

  logic [1:0] state;
  logic [3:0] wait_cnt;
  logic       req_in;

  assign req_in = bus.mem_read | bus.mem_write;

  // Combinational so the pipeline freezes in the same cycle the request appears.
  assign bus.stall = ((state == IDLE) && req_in) || (state == BUSY);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      wait_cnt         <= 4'd0;
      bus.dm_req       <= 1'b0;
      bus.dm_we        <= 1'b0;
      bus.dm_addr      <= 32'd0;
      bus.dm_wdata     <= 32'd0;
      bus.wb_valid     <= 1'b0;
      bus.wb_read_data <= 32'd0;
      bus.err          <= 1'b0;
    end else begin
      bus.wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_in) begin
            state        <= BUSY;
            wait_cnt     <= 4'd0;
            bus.dm_req   <= 1'b1;
            bus.dm_we    <= bus.mem_write;
            bus.dm_addr  <= bus.addr;
            bus.dm_wdata <= bus.wdata;
            if (bus.mem_read && bus.mem_write) begin
              bus.err <= 1'b1;
            end
          end
        end

        BUSY: begin
          // Ack is tested first so it wins over a coincident timeout.
          if (bus.dm_ack) begin
            state        <= DONE;
            bus.dm_req   <= 1'b0;
            bus.wb_valid <= 1'b1;
            if (!bus.dm_we) begin
              bus.wb_read_data <= bus.dm_rdata;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            state            <= DONE;
            bus.dm_req       <= 1'b0;
            bus.wb_valid     <= 1'b1;
            bus.wb_read_data <= 32'd0;
            bus.err          <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the max BUSY cycles waited for dm_ack (range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port mem_read, input, 1 bit: the MEM-stage instruction is a load.
REQ-005 The block SHALL have port mem_write, input, 1 bit: the MEM-stage instruction is a store.
REQ-006 The block SHALL have port addr, input, 32 bits: the MEM-stage effective address (alu_result).
REQ-007 The block SHALL have port wdata, input, 32 bits: the MEM-stage store data.
REQ-008 The block SHALL have port dm_req, output, 1 bit: registered data-memory request.
REQ-009 The block SHALL have port dm_we, output, 1 bit: registered write enable for the request.
REQ-010 The block SHALL have ports dm_addr and dm_wdata, output, 32 bits each: registered request address and data.
REQ-011 The block SHALL have port dm_ack, input, 1 bit: memory has completed the request.
REQ-012 The block SHALL have port dm_rdata, input, 32 bits: load data, valid while dm_ack=1.
REQ-013 The block SHALL have port stall, output, 1 bit: freezes PC, IF/ID, ID/EX, EX/MEM and holds MEM/WB.
REQ-014 The block SHALL have port wb_valid, output, 1 bit: the access completed this cycle; MEM/WB may load.
REQ-015 The block SHALL have port wb_read_data, output, 32 bits: captured load data, fed to MEM/WB read_data.
REQ-016 The block SHALL have port err, output, 1 bit: sticky fault flag.

Function
REQ-017 States SHALL be IDLE, BUSY, DONE, held in a registered state variable.
REQ-018 IDLE, (mem_read|mem_write)=1: next state BUSY; at the edge latch dm_addr=addr, dm_wdata=wdata, dm_we=mem_write, dm_req=1, clear wait counter.
REQ-019 IDLE, no request: remain IDLE; dm_req=0; latched registers keep old values.
REQ-020 stall SHALL be combinational: 1 in IDLE with a request pending, 1 in BUSY, 0 in DONE and in IDLE without a request.
REQ-021 BUSY, dm_ack=1: next state DONE; dm_req cleared; if dm_we=0, wb_read_data<=dm_rdata, else wb_read_data unchanged.
REQ-022 BUSY, dm_ack=0: 4-bit wait counter increments each cycle; dm_req and latched fields held stable.
REQ-023 BUSY, counter==TIMEOUT-1 and dm_ack=0: next state DONE, dm_req cleared, wb_read_data<=0, err<=1.
REQ-024 dm_ack and timeout in the same cycle: ack SHALL win; no error set.
REQ-025 DONE: wb_valid=1 (registered, exactly one cycle), stall=0; next state IDLE unconditionally.
REQ-026 In DONE, mem_read/mem_write SHALL be ignored (they still reflect the completing instruction).
REQ-027 mem_read and mem_write both 1 in IDLE: treated as store (dm_we=1) and err<=1.
REQ-028 dm_ack in IDLE or DONE SHALL be ignored.
REQ-029 Minimum access latency: request seen in IDLE cycle n, dm_req high from n+1, ack at n+1 gives wb_valid at n+2; 3 cycles total.
REQ-030 err SHALL remain 1 until reset.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, wb_valid=0, wb_read_data=0, err=0, counter=0.
REQ-032 reset SHALL take priority over every transition, including mid-BUSY; an outstanding request is abandoned, with dm_req=0 the cycle after.
REQ-033 During the reset cycle, stall SHALL follow REQ-020 from the pre-reset state; after the reset cycle, stall=0 unless a request is present.

Verification
REQ-034 Load, addr=0x10, ack one cycle after dm_req, dm_rdata=0xDEADBEEF -> stall high 2 cycles, wb_valid pulse in cycle 3, wb_read_data=0xDEADBEEF, err=0.
REQ-035 Store, addr=0x20, wdata=0x12345678, ack after 4 wait cycles -> dm_we=1, dm_addr/dm_wdata stable throughout BUSY, stall high 6 cycles, wb_read_data unchanged.
REQ-036 Load with no ack, TIMEOUT=15 -> DONE after 15 BUSY cycles, wb_read_data=0, err=1 and held through later clean accesses.
REQ-037 Ack on the exact timeout cycle -> normal completion, err=0, data captured.
REQ-038 Reset asserted on the 3rd BUSY cycle -> next cycle IDLE, dm_req=0, all outputs zero, no wb_valid pulse.
REQ-039 Back-to-back loads, with the second instruction presented in the DONE cycle -> second request accepted only from IDLE, two distinct wb_valid pulses, no request dropped or duplicated.
